// File: rtl/line_burst_adaptor_pkg.sv
// Shared constants and state type for the line/burst adaptor.
//   LINE_W  : cache line width in bits
//   BURST_W : memory beat width in bits
//   BEATS   : beats per line (power of two, >= 2)
//   ADDR_W  : address width
//   OFFSET  : byte-offset bits inside one line
//   CNT_W   : beat counter width
package line_burst_adaptor_pkg;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int ADDR_W  = 32;
  localparam int OFFSET  = $clog2(LINE_W / 8);
  localparam int CNT_W   = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } line_burst_state_t;
endpackage

// File: rtl/line_burst_adaptor_if.sv
// Bundles the cache-side (line-wide) and memory-side (beat-wide) signals.
//   slave  : adaptor view (requests and read beats in; line, status, write beats out)
//   master : cache/memory environment view (mirror of slave)
interface line_burst_adaptor_if;
  import line_burst_adaptor_pkg::*;

  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic               resp_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic               resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/line_burst_adaptor.sv
// Moves whole cache lines over a narrower burst bus: a read assembles BEATS
// incoming beats into line_o, a write splits the latched line into beats.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : line_burst_adaptor_if.slave (cache request/line and memory beat signals)
//
// state | meaning
// IDLE  | waiting for read_i/write_i; latches address and line on exit
// READ  | read_o high, each resp_i stores one beat into line_o
// WRITE | write_o high, burst_o shows current beat, resp_i advances
// DONE  | one-cycle resp_o pulse, then back to IDLE
module line_burst_adaptor
  import line_burst_adaptor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  line_burst_adaptor_if.slave bus
);

  line_burst_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rline_q, rline_d;

  // Byte-offset bits are deliberately dropped from the memory address.
  logic unused_offset;
  assign unused_offset = ^bus.address_i[OFFSET-1:0];

  logic last_beat;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        if (bus.write_i || bus.read_i) begin
          state_d = bus.write_i ? WRITE : READ;
          addr_d  = {bus.address_i[ADDR_W-1:OFFSET], {OFFSET{1'b0}}};
          wline_d = bus.line_i;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          rline_d[int'(cnt_q)*BURST_W +: BURST_W] = bus.burst_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      WRITE: begin
        if (bus.resp_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only, so resp_i never reaches them
  // combinationally. burst_o only moves when cnt advances on an accepted beat.
  assign bus.read_o    = (state_q == READ);
  assign bus.write_o   = (state_q == WRITE);
  assign bus.resp_o    = (state_q == DONE);
  assign bus.address_o = addr_q;
  assign bus.line_o    = rline_q;
  assign bus.burst_o   = wline_q[int'(cnt_q)*BURST_W +: BURST_W];

endmodule

// File: tb/tb_line_burst_adaptor.sv
module tb_line_burst_adaptor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_burst_adaptor_if bus_if();

  line_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [255:0] exp_line = '0;   // what line_o must hold: last read beats, zero after reset
  logic [31:0]  exp_addr = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Full line read. Expected line is the beats in delivery order, beat 0 lowest.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] data,
                         input int stall_pct, input string nm);
    int beats;
    int run;
    int cyc;
    logic r;
    bus_if.address_i = addr;
    bus_if.read_i    = 1'b1;
    bus_if.write_i   = 1'b0;
    bus_if.resp_i    = 1'b0;
    tick();
    exp_addr = {addr[31:5], 5'b0};
    beats = 0; run = 0; cyc = 0;
    while (beats < 4 && cyc < 100) begin
      tests++; if (bus_if.read_o !== 1'b1 || bus_if.write_o !== 1'b0 || bus_if.resp_o !== 1'b0) begin fails++; $display("FAIL %s rd_active: read_o=%b write_o=%b resp_o=%b want 1 0 0", nm, bus_if.read_o, bus_if.write_o, bus_if.resp_o); end
      tests++; if (bus_if.address_o !== exp_addr) begin fails++; $display("FAIL %s rd_addr: got %h want %h", nm, bus_if.address_o, exp_addr); end
      r = ($urandom_range(99) >= stall_pct) || (run >= 4);
      bus_if.resp_i  = r;
      bus_if.burst_i = r ? data[beats*64 +: 64] : 64'($urandom);
      tick();
      if (r) begin exp_line[beats*64 +: 64] = data[beats*64 +: 64]; beats++; run = 0; end
      else run++;
      cyc++;
    end
    bus_if.resp_i = 1'b1;            // stray accept in DONE must be ignored
    bus_if.burst_i = 64'($urandom);
    tests++; if (bus_if.resp_o !== 1'b1 || bus_if.read_o !== 1'b0) begin fails++; $display("FAIL %s rd_done: resp_o=%b read_o=%b want 1 0", nm, bus_if.resp_o, bus_if.read_o); end
    tests++; if (bus_if.line_o !== exp_line) begin fails++; $display("FAIL %s rd_line: got %h want %h", nm, bus_if.line_o, exp_line); end
    tick();
    bus_if.read_i = 1'b0;
    bus_if.resp_i = 1'b0;
    tests++; if (bus_if.resp_o !== 1'b0 || bus_if.read_o !== 1'b0 || bus_if.write_o !== 1'b0) begin fails++; $display("FAIL %s rd_idle: resp_o=%b read_o=%b write_o=%b want 0 0 0", nm, bus_if.resp_o, bus_if.read_o, bus_if.write_o); end
    tests++; if (bus_if.line_o !== exp_line) begin fails++; $display("FAIL %s rd_hold: got %h want %h", nm, bus_if.line_o, exp_line); end
  endtask

  // Full line write. period>0: accept every period-th cycle; period==0: random.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] data,
                          input int period, input bit also_read, input string nm);
    int beats;
    int cyc;
    logic r;
    bus_if.address_i = addr;
    bus_if.line_i    = data;
    bus_if.write_i   = 1'b1;
    bus_if.read_i    = also_read;
    bus_if.resp_i    = 1'b0;
    tick();
    bus_if.line_i = rand_line();      // latched copy must be used, not the live input
    exp_addr = {addr[31:5], 5'b0};
    beats = 0; cyc = 0;
    while (beats < 4 && cyc < 100) begin
      tests++; if (bus_if.write_o !== 1'b1 || bus_if.read_o !== 1'b0 || bus_if.resp_o !== 1'b0) begin fails++; $display("FAIL %s wr_active: write_o=%b read_o=%b resp_o=%b want 1 0 0", nm, bus_if.write_o, bus_if.read_o, bus_if.resp_o); end
      tests++; if (bus_if.burst_o !== data[beats*64 +: 64]) begin fails++; $display("FAIL %s wr_beat%0d: got %h want %h", nm, beats, bus_if.burst_o, data[beats*64 +: 64]); end
      tests++; if (bus_if.line_o !== exp_line || bus_if.address_o !== exp_addr) begin fails++; $display("FAIL %s wr_side: line_o=%h addr=%h want %h %h", nm, bus_if.line_o, bus_if.address_o, exp_line, exp_addr); end
      if (period == 0) r = ($urandom_range(2) == 0) || (cyc % 5 == 4);
      else r = ((cyc % period) == period - 1);
      bus_if.resp_i = r;
      tick();
      if (r) beats++;
      cyc++;
    end
    bus_if.resp_i = 1'b1;
    tests++; if (bus_if.resp_o !== 1'b1 || bus_if.write_o !== 1'b0 || bus_if.read_o !== 1'b0) begin fails++; $display("FAIL %s wr_done: resp_o=%b write_o=%b read_o=%b want 1 0 0", nm, bus_if.resp_o, bus_if.write_o, bus_if.read_o); end
    tick();
    bus_if.write_i = 1'b0;
    bus_if.read_i  = 1'b0;
    bus_if.resp_i  = 1'b0;
    tests++; if (bus_if.resp_o !== 1'b0 || bus_if.write_o !== 1'b0 || bus_if.line_o !== exp_line) begin fails++; $display("FAIL %s wr_idle: resp_o=%b write_o=%b line_o=%h want 0 0 %h", nm, bus_if.resp_o, bus_if.write_o, bus_if.line_o, exp_line); end
  endtask

  task automatic test_reset();
    logic [255:0] d;
    rst = 1'b0;
    bus_if.read_i = 1'b1; bus_if.write_i = 1'b0; bus_if.resp_i = 1'b0;
    bus_if.address_i = 32'h0000_125C; bus_if.line_i = rand_line(); bus_if.burst_i = '0;
    tick(); tick();
    tests++; if ({bus_if.read_o, bus_if.write_o, bus_if.resp_o} !== 3'b000) begin fails++; $display("FAIL reset_ctl: r/w/resp=%b want 000", {bus_if.read_o, bus_if.write_o, bus_if.resp_o}); end
    tests++; if (bus_if.line_o !== '0 || bus_if.address_o !== '0 || bus_if.burst_o !== '0) begin fails++; $display("FAIL reset_data: line=%h addr=%h burst=%h want 0", bus_if.line_o, bus_if.address_o, bus_if.burst_o); end
    rst = 1'b1;
    tick();
    tests++; if (bus_if.read_o !== 1'b1) begin fails++; $display("FAIL reset_release_rd: read_o=%b want 1", bus_if.read_o); end
    tests++; if (bus_if.address_o !== 32'h0000_1240) begin fails++; $display("FAIL reset_release_addr: got %h want 00001240", bus_if.address_o); end
    d = rand_line();
    for (int i = 0; i < 4; i++) begin
      bus_if.resp_i = 1'b1; bus_if.burst_i = d[i*64 +: 64];
      tick();
    end
    exp_line = d;
    bus_if.resp_i = 1'b0;
    tests++; if (bus_if.resp_o !== 1'b1 || bus_if.line_o !== exp_line) begin fails++; $display("FAIL reset_first_read: resp_o=%b line=%h want 1 %h", bus_if.resp_o, bus_if.line_o, exp_line); end
    tick();
    bus_if.read_i = 1'b0;
  endtask

  task automatic test_zero_stall_read();
    do_read(32'h8000_0047, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, "zs_read");
  endtask

  task automatic test_stalled_write();
    do_write(32'h0000_A0FF, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                             64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 3, 1'b0, "st_write");
  endtask

  task automatic test_priority_and_stray();
    bus_if.read_i = 1'b0; bus_if.write_i = 1'b0; bus_if.resp_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({bus_if.read_o, bus_if.write_o, bus_if.resp_o} !== 3'b000 || bus_if.address_o !== exp_addr) begin fails++; $display("FAIL stray_idle: r/w/resp=%b addr=%h want 000 %h", {bus_if.read_o, bus_if.write_o, bus_if.resp_o}, bus_if.address_o, exp_addr); end
    end
    bus_if.resp_i = 1'b0;
    do_write(32'h1234_5678, rand_line(), 1, 1'b1, "both_req");
  endtask

  task automatic test_reset_mid_read();
    logic [255:0] d;
    d = rand_line();
    bus_if.address_i = 32'h0000_3000; bus_if.read_i = 1'b1; bus_if.resp_i = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus_if.resp_i = 1'b1; bus_if.burst_i = d[i*64 +: 64];
      tick();
    end
    rst = 1'b0; bus_if.read_i = 1'b0; bus_if.resp_i = 1'b0;
    tick();
    exp_line = '0; exp_addr = '0;
    tests++; if (bus_if.read_o !== 1'b0 || bus_if.resp_o !== 1'b0) begin fails++; $display("FAIL midrst_ctl: read_o=%b resp_o=%b want 0 0", bus_if.read_o, bus_if.resp_o); end
    tests++; if (bus_if.line_o !== '0) begin fails++; $display("FAIL midrst_line: got %h want 0", bus_if.line_o); end
    rst = 1'b1;
    tick();
    tests++; if (bus_if.resp_o !== 1'b0 || bus_if.read_o !== 1'b0) begin fails++; $display("FAIL midrst_after: resp_o=%b read_o=%b want 0 0", bus_if.resp_o, bus_if.read_o); end
    do_read(32'h0000_3010, rand_line(), 40, "midrst_fresh");
  endtask

  task automatic test_back_to_back();
    do_read(32'h0000_5500, rand_line(), 30, "b2b_read");
    do_write(32'h0000_6600, rand_line(), 0, 1'b0, "b2b_write");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(1) == 0) do_read($urandom, rand_line(), $urandom_range(60), "rnd_read");
      else do_write($urandom, rand_line(), $urandom_range(3), 1'($urandom_range(1)), "rnd_write");
      if ($urandom_range(1) == 0) tick();
    end
  endtask

  initial begin
    bus_if.address_i = '0; bus_if.read_i = 1'b0; bus_if.write_i = 1'b0;
    bus_if.line_i = '0; bus_if.burst_i = '0; bus_if.resp_i = 1'b0;
    test_reset();
    test_zero_stall_read();
    test_stalled_write();
    test_priority_and_stray();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
